// File: rtl/hiscore_ram_arbiter.sv
// hiscore_ram_arbiter
// Shares one score-RAM port between the game CPU and the hiscore engine.
// When the engine asks for the port, the arbiter halts the CPU and waits a
// settle period before handing the port over. It holds the CPU halted for a
// matching settle period after the engine lets go. RAM read data goes back to
// the engine through a registered capture stage.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   hs_pause          engine requests the port
//   hs_address/data   engine RAM address / write data
//   hs_write          engine write strobe
//   hs_dout           registered RAM read data to the engine
//   cpu_address/data  CPU RAM address / write data
//   cpu_write         CPU write strobe
//   cpu_pause         halt request to the CPU
//   ram_address/data  muxed RAM address / write data
//   ram_write         muxed RAM write strobe
//   ram_q             RAM read data (1-cycle read latency)
//   owner             1 = hiscore engine owns the port
//   hs_write_dropped  sticky: hs_write seen while the engine did not own the port
module hiscore_ram_arbiter #(
    parameter int ADDRESSWIDTH  = 10,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    hs_pause,
    input  logic [ADDRESSWIDTH-1:0] hs_address,
    input  logic [7:0]              hs_data,
    input  logic                    hs_write,
    output logic [7:0]              hs_dout,
    input  logic [ADDRESSWIDTH-1:0] cpu_address,
    input  logic [7:0]              cpu_data,
    input  logic                    cpu_write,
    output logic                    cpu_pause,
    output logic [ADDRESSWIDTH-1:0] ram_address,
    output logic [7:0]              ram_data,
    output logic                    ram_write,
    input  logic [7:0]              ram_q,
    output logic                    owner,
    output logic                    hs_write_dropped
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HALT    = 2'd1,
        HS      = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [7:0] counter;

    // Port mux follows the registered owner. CPU writes are blocked while
    // the CPU is being halted or released.
    always_comb begin
        ram_address = cpu_address;
        ram_data    = cpu_data;
        ram_write   = 1'b0;
        if (owner) begin
            ram_address = hs_address;
            ram_data    = hs_data;
            ram_write   = hs_write;
        end else if (state == IDLE) begin
            ram_write   = cpu_write;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            owner            <= 1'b0;
            cpu_pause        <= 1'b0;
            hs_dout          <= '0;
            counter          <= '0;
            hs_write_dropped <= 1'b0;
        end else begin
            if (hs_write && !owner)
                hs_write_dropped <= 1'b1;

            case (state)
                IDLE: begin
                    if (hs_pause) begin
                        state     <= HALT;
                        cpu_pause <= 1'b1;
                        counter   <= SETTLE_LOAD;
                    end
                end
                HALT: begin
                    if (!hs_pause) begin
                        state     <= IDLE;
                        cpu_pause <= 1'b0;
                    end else if (counter == 8'd0) begin
                        state <= HS;
                        owner <= 1'b1;
                    end else begin
                        counter <= counter - 8'd1;
                    end
                end
                HS: begin
                    hs_dout <= ram_q;
                    if (!hs_pause) begin
                        state   <= RELEASE;
                        owner   <= 1'b0;
                        counter <= SETTLE_LOAD;
                    end
                end
                RELEASE: begin
                    // The CPU is still halted, so a new request can take the
                    // port straight back without another settle period.
                    if (hs_pause) begin
                        state <= HS;
                        owner <= 1'b1;
                    end else if (counter == 8'd0) begin
                        state     <= IDLE;
                        cpu_pause <= 1'b0;
                    end else begin
                        counter <= counter - 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Scoreboard bench for hiscore_ram_arbiter. The stimulus process queues
// expected values tagged with the clock cycle they apply to. A monitor
// compares them on the falling edge of that cycle.
module tb_hiscore_ram_arbiter;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          hs_pause;
    logic [AW-1:0] hs_address;
    logic [7:0]    hs_data;
    logic          hs_write;
    logic [7:0]    hs_dout;
    logic [AW-1:0] cpu_address;
    logic [7:0]    cpu_data;
    logic          cpu_write;
    logic          cpu_pause;
    logic [AW-1:0] ram_address;
    logic [7:0]    ram_data;
    logic          ram_write;
    logic [7:0]    ram_q;
    logic          owner;
    logic          hs_write_dropped;

    hiscore_ram_arbiter #(.ADDRESSWIDTH(AW), .SETTLE_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .hs_pause(hs_pause), .hs_address(hs_address), .hs_data(hs_data),
        .hs_write(hs_write), .hs_dout(hs_dout),
        .cpu_address(cpu_address), .cpu_data(cpu_data), .cpu_write(cpu_write),
        .cpu_pause(cpu_pause),
        .ram_address(ram_address), .ram_data(ram_data), .ram_write(ram_write),
        .ram_q(ram_q), .owner(owner), .hs_write_dropped(hs_write_dropped)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model with 1-cycle read latency.
    logic [7:0] mem [0:(1<<AW)-1];
    initial for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    initial ram_q = 8'h00;
    always @(posedge clk) begin
        ram_q <= mem[ram_address];
        if (ram_write) mem[ram_address] <= ram_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int S_OWNER = 0, S_PAUSE = 1, S_WR = 2, S_ADDR = 3,
                   S_DATA = 4, S_DOUT = 5, S_DROP = 6;

    typedef struct {
        string name;
        int    at;
        int    sig;
        int    val;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    task automatic expect_at(input string name, input int sig, input int val,
                             input int delay = 0);
        exp_t e;
        e.name = name;
        e.at   = cyc + delay;
        e.sig  = sig;
        e.val  = val;
        q.push_back(e);
    endtask

    function automatic int actual(input int sig);
        case (sig)
            S_OWNER: return int'(owner);
            S_PAUSE: return int'(cpu_pause);
            S_WR:    return int'(ram_write);
            S_ADDR:  return int'(ram_address);
            S_DATA:  return int'(ram_data);
            S_DOUT:  return int'(hs_dout);
            default: return int'(hs_write_dropped);
        endcase
    endfunction

    // Monitor: compare every expectation due this cycle. An entry that is
    // overdue was missed, so it counts as an error.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].at <= cyc) begin
                int a;
                a = actual(q[i].sig);
                checks++;
                if (q[i].at < cyc || a != q[i].val) begin
                    errors++;
                    $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                             q[i].name, a, q[i].val, cyc);
                end
                q.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; hs_pause = 1'b0; hs_address = '0; hs_data = '0;
        hs_write = 1'b0; cpu_address = '0; cpu_data = '0; cpu_write = 1'b0;
        step(); step();
        expect_at("rst_owner", S_OWNER, 0);
        expect_at("rst_pause", S_PAUSE, 0);
        expect_at("rst_dout",  S_DOUT,  8'h00);
        expect_at("rst_drop",  S_DROP,  0);
        step();
        reset = 1'b0;

        // CPU write passes straight through in IDLE.
        cpu_address = 10'h020; cpu_data = 8'h5A; cpu_write = 1'b1;
        expect_at("cpu_wr",    S_WR,    1);
        expect_at("cpu_addr",  S_ADDR,  10'h020);
        expect_at("cpu_data",  S_DATA,  8'h5A);
        expect_at("cpu_owner", S_OWNER, 0);
        expect_at("cpu_pause", S_PAUSE, 0);
        step();

        // Grant: hs_pause sampled at edge t, owner at t+4.
        cpu_address = 10'h030; cpu_data = 8'h77;
        hs_pause = 1'b1;
        step();                                  // edge t
        for (int k = 0; k < 4; k++) begin
            expect_at($sformatf("halt_pause%0d", k), S_PAUSE, 1);
            expect_at($sformatf("halt_wrgate%0d", k), S_WR, 0);
            expect_at($sformatf("halt_owner%0d", k), S_OWNER, 0);
            step();
        end
        cpu_write = 1'b0;                        // now at t+4
        expect_at("grant_owner", S_OWNER, 1);
        hs_address = 10'h043; hs_data = 8'h10; hs_write = 1'b1;
        expect_at("hs_wr",   S_WR,   1);
        expect_at("hs_addr", S_ADDR, 10'h043);
        expect_at("hs_data", S_DATA, 8'h10);
        step();
        expect_at("hs_nodrop", S_DROP, 0);

        // Read-back latency: write 0xAB to 0x12E, then read it.
        hs_address = 10'h12E; hs_data = 8'hAB; hs_write = 1'b1;
        step();
        hs_write = 1'b0;                         // cycle c: address presented
        expect_at("rd_lat1", S_DOUT, 8'h00, 1);
        expect_at("rd_lat2", S_DOUT, 8'hAB, 2);
        step(); step(); step();
        hs_pause = 1'b0;
        step();                                  // RELEASE, counter 3
        cpu_write = 1'b1; cpu_address = 10'h055; cpu_data = 8'hEE;
        expect_at("rel_owner", S_OWNER, 0);
        expect_at("rel_pause", S_PAUSE, 1);
        expect_at("rel_hold",  S_DOUT,  8'hAB);
        expect_at("rel_wrgate", S_WR,   0);
        step();                                  // RELEASE, counter 2
        expect_at("rel2_pause", S_PAUSE, 1);
        hs_pause = 1'b1;
        step();
        cpu_write = 1'b0;
        expect_at("regrant_owner", S_OWNER, 1);
        expect_at("regrant_pause", S_PAUSE, 1);

        // Reset during HS.
        step();
        reset = 1'b1;
        step();
        expect_at("rstHS_owner", S_OWNER, 0);
        expect_at("rstHS_pause", S_PAUSE, 0);
        expect_at("rstHS_dout",  S_DOUT,  8'h00);
        reset = 1'b0; hs_pause = 1'b0;
        cpu_address = 10'h077; cpu_data = 8'h3C; cpu_write = 1'b1;
        expect_at("rstHS_cpuwr",   S_WR,   1);
        expect_at("rstHS_cpuaddr", S_ADDR, 10'h077);
        step();
        cpu_write = 1'b0;

        // Aborted request: two cycles of hs_pause, hs_write while not owner.
        hs_pause = 1'b1;
        step();                                  // HALT
        expect_at("abort_pause1", S_PAUSE, 1);
        hs_write = 1'b1; hs_address = 10'h099; hs_data = 8'h42;
        expect_at("abort_hswr_gated", S_WR, 0);
        step();
        hs_write = 1'b0; hs_pause = 1'b0;
        expect_at("abort_drop", S_DROP, 1);
        expect_at("abort_owner", S_OWNER, 0);
        step();                                  // back in IDLE
        expect_at("abort_unpause", S_PAUSE, 0);
        expect_at("abort_owner2",  S_OWNER, 0);
        step(); step();
        expect_at("drop_sticky", S_DROP, 1);
        expect_at("abort_owner3", S_OWNER, 0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        expect_at("drop_clear", S_DROP, 0);
        step(); step();

        done = 1'b1;
        if (q.size() != 0) begin
            errors += q.size();
            checks += q.size();
            $display("FAIL scoreboard_leftover: got %0d pending, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL watchdog: got timeout, expected completion");
            $fatal(1, "timeout");
        end
    end

endmodule
